seg_scan_ctrl: RTL



---
 rtl/seg_scan_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for NUM_DIGITS common-anode
// 7-segment digits sharing one hex decoder. A double-buffered frame is loaded
// through a ready/load handshake. The new frame takes effect only at a frame
// boundary, so a displayed frame never mixes old and new digits.
//
// Optional feature macro: SEG_SCAN_BLINK_EN
//   When it is defined, the block adds the blink_mask input and a 6-bit frame
//   counter. The counter MSB is the blink phase. While the phase is 1, digits
//   whose blink bit is set stay dark.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   load        one-cycle capture request, accepted only while ready=1
//   data        digit nibbles, digit k = data[4k+3:4k]
//   blank_mask  1 = digit k dark
//   blink_mask  (SEG_SCAN_BLINK_EN only) 1 = digit k blinks
//   ready       1 = shadow buffer free
//   inp_out     nibble to the decoder input
//   anode       active-low digit enables
//   digit_idx   digit currently scanned
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIV          = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       data,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]         blink_mask,
`endif
  output logic                          ready,
  output logic [3:0]                    inp_out,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DAT_W = 4 * NUM_DIGITS;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DAT_W-1:0]      r_act_data, r_shd_data;
  logic [NUM_DIGITS-1:0] r_act_mask, r_shd_mask;

  logic                  w_slot_end, w_frame_end, w_commit, w_nxt_show;
  logic [CNT_W-1:0]      w_nxt_cnt;
  logic [IDX_W-1:0]      w_nxt_idx;
  logic [DAT_W-1:0]      w_nxt_act_data;
  logic [NUM_DIGITS-1:0] w_nxt_act_mask;
  logic [NUM_DIGITS-1:0] w_blink_dark;
  logic [NUM_DIGITS-1:0] w_lit;
  logic [3:0]            w_nxt_nibble;

  // Slot, digit and frame sequencing, as the values they take after this edge.
  assign w_slot_end  = (r_cnt == CNT_W'(DIV - 1));
  assign w_frame_end = w_slot_end && (digit_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_commit    = w_frame_end && !ready;
  assign w_nxt_cnt   = w_slot_end ? '0 : r_cnt + CNT_W'(1);
  assign w_nxt_idx   = !w_slot_end ? digit_idx :
                       (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
  assign w_nxt_show  = (w_nxt_cnt >= CNT_W'(BLANK_CYCLES));

  // The active frame as it will be after this edge. A commit edge already uses the new frame.
  assign w_nxt_act_data = w_commit ? r_shd_data : r_act_data;
  assign w_nxt_act_mask = w_commit ? r_shd_mask : r_act_mask;
  assign w_nxt_nibble   = w_nxt_act_data[4*w_nxt_idx +: 4];

`ifdef SEG_SCAN_BLINK_EN
  logic [5:0]            r_frame;
  logic [5:0]            w_nxt_frame;
  logic [NUM_DIGITS-1:0] r_act_blink, r_shd_blink;
  logic [NUM_DIGITS-1:0] w_nxt_act_blink;

  assign w_nxt_frame     = w_frame_end ? r_frame + 6'd1 : r_frame;
  assign w_nxt_act_blink = w_commit ? r_shd_blink : r_act_blink;
  assign w_blink_dark    = {NUM_DIGITS{w_nxt_frame[5]}} & w_nxt_act_blink;

  // Frame counter and the blink mask buffers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame     <= '0;
      r_act_blink <= '0;
      r_shd_blink <= '0;
    end else begin
      r_frame <= w_nxt_frame;
      if (load && ready)
        r_shd_blink <= blink_mask;
      else if (w_commit)
        r_act_blink <= r_shd_blink;
    end
  end
`else
  assign w_blink_dark = '0;
`endif

  // One-hot active-high enable for the digit shown in the next slot.
  always_comb begin
    w_lit = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IDX_W'(k) == w_nxt_idx)
        w_lit[k] = ~w_nxt_act_mask[k] & ~w_blink_dark[k];
    end
  end

  // Scan FSM, the frame buffers and the registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_BLANK;
      r_cnt      <= '0;
      digit_idx  <= '0;
      anode      <= '1;
      inp_out    <= '0;
      ready      <= 1'b1;
      r_act_data <= '0;
      r_shd_data <= '0;
      r_act_mask <= '1;
      r_shd_mask <= '1;
    end else begin
      r_cnt     <= w_nxt_cnt;
      digit_idx <= w_nxt_idx;

      case (r_state)
        ST_BLANK: if (w_nxt_show)  r_state <= ST_SHOW;
        ST_SHOW:  if (!w_nxt_show) r_state <= ST_BLANK;
        default:  r_state <= ST_BLANK;
      endcase
      anode <= w_nxt_show ? ~w_lit : '1;

      // The nibble changes only at a digit change, so it is stable through BLANK.
      if (w_slot_end)
        inp_out <= w_nxt_nibble;

      // A load is accepted only while ready=1, and a commit needs ready=0, so the two never collide.
      if (load && ready) begin
        r_shd_data <= data;
        r_shd_mask <= blank_mask;
        ready      <= 1'b0;
      end else if (w_commit) begin
        r_act_data <= r_shd_data;
        r_act_mask <= r_shd_mask;
        ready      <= 1'b1;
      end
    end
  end

endmodule
